// File: rtl/event_parity_if.sv
// 23-bit GigaFitter word stream link: data/EE/valid flow forward, hold flows back.
interface event_parity_if;
  logic [22:0] data;
  logic        ee;
  logic        valid;
  logic        hold;

  modport master (output data, ee, valid, input  hold);
  modport slave  (input  data, ee, valid, output hold);
endinterface

// File: rtl/event_parity_ctrl.sv
// In-line per-event parity checker for the GigaFitter stream: one register stage,
// running-XOR over data words vs. the EE parity bit, event length bound, status counters.
module event_parity_ctrl #(
  parameter int PAR_BIT   = 21,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  event_parity_if.slave      i_up,
  event_parity_if.master     o_dn,
  input  logic               i_clear_counts,
  output logic               o_par_err,
  output logic               o_len_err,
  output logic [CNT_W-1:0]   o_err_count,
  output logic [CNT_W-1:0]   o_evt_count
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_acc, w_acc_nxt;
  logic [WC_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic              w_accept, w_par_err, w_len_err;

  logic [22:0]       r_data;
  logic              r_ee, r_valid, r_par_err, r_len_err;
  logic [CNT_W-1:0]  r_err_count, r_evt_count;

  assign i_up.hold = o_dn.hold;
  assign w_accept  = i_up.valid & ~o_dn.hold;

  // Nothing moves unless a word is accepted, so hold freezes state implicitly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_acc      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_word_cnt_nxt = r_word_cnt;
    w_par_err      = 1'b0;
    w_len_err      = 1'b0;
    if (w_accept) begin
      if (i_up.ee) begin
        // acc is zero in IDLE, so an empty event must carry parity 0
        if (r_state != DRAIN) w_par_err = i_up.data[PAR_BIT] ^ r_acc;
        w_state_nxt    = IDLE;
        w_acc_nxt      = 1'b0;
        w_word_cnt_nxt = '0;
      end else if (r_state != DRAIN) begin
        if (r_word_cnt == WC_W'(MAX_WORDS)) begin
          w_len_err   = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          w_word_cnt_nxt = r_word_cnt + WC_W'(1);
          w_acc_nxt      = r_acc ^ (^i_up.data);
          w_state_nxt    = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data      <= '0;
      r_ee        <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_err_count <= '0;
      r_evt_count <= '0;
    end else begin
      if (!o_dn.hold) begin
        r_data    <= i_up.data;
        r_ee      <= i_up.ee;
        r_valid   <= w_accept;
        r_par_err <= w_par_err;
        r_len_err <= w_len_err;
        if (w_accept && i_up.ee)
          r_evt_count <= r_evt_count + CNT_W'(1);
        if ((w_par_err || w_len_err) && (r_err_count != {CNT_W{1'b1}}))
          r_err_count <= r_err_count + CNT_W'(1);
      end
      // clear beats any same-cycle increment and ignores hold
      if (i_clear_counts) begin
        r_err_count <= '0;
        r_evt_count <= '0;
      end
    end
  end

  assign o_dn.data   = r_data;
  assign o_dn.ee     = r_ee;
  assign o_dn.valid  = r_valid;
  assign o_par_err   = r_par_err;
  assign o_len_err   = r_len_err;
  assign o_err_count = r_err_count;
  assign o_evt_count = r_evt_count;
endmodule

// File: doc/event_parity_ctrl.md
# event_parity_ctrl

Per-event parity sequencer for the 23-bit GigaFitter word stream. It sits in-line between an upstream FIFO/link and the next stage, forwarding words with one register stage. It runs a running-XOR accumulator over each event's data words and checks it against the parity bit carried in the end-of-event (EE) word. It also bounds event length and keeps saturating error and wrapping event counters for the VME status path.

## Interface
Parameters:
- PAR_BIT, 21, bit index of in_data in the EE word that carries the expected event parity (0..22)
- MAX_WORDS, 1024, maximum non-EE words per event; larger events are length errors
- CNT_W, 16, width of err_count and evt_count

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  23  data word
- in_ee  in  1  word is the end-of-event word
- in_valid  in  1  word present
- in_hold  out  1  backpressure to upstream; combinationally equal to out_hold
- out_data  out  23  forwarded word
- out_ee  out  1  forwarded EE flag
- out_valid  out  1  forwarded word valid
- out_hold  in  1  backpressure from downstream
- par_err  out  1  one-cycle pulse, aligned with out_valid of the failing EE word
- len_err  out  1  one-cycle pulse, aligned with out_valid of the word that overflows MAX_WORDS
- err_count  out  CNT_W  parity+length errors, saturating at all-ones
- evt_count  out  CNT_W  EE words accepted, wraps
- clear_counts  in  1  synchronous clear of err_count and evt_count

## Operation
- accept = in_valid & ~out_hold. When out_hold=1, all output registers, acc, word_cnt, state and counters hold.
- Output register, when ~out_hold: out_data<=in_data, out_ee<=in_ee, out_valid<=accept, par_err/len_err <= computed flags (0 when not accepted).
- Accumulator acc (1 bit):
  - On an accepted non-EE word in IDLE/ACCUM: acc <= acc ^ (^in_data).
  - The EE word is excluded from the computation.
  - On an accepted EE word in any state: acc <= 0, word_cnt <= 0.
- States:
  - IDLE: no data words in the current event yet.
    - Accepted non-EE word -> ACCUM.
    - Accepted EE word -> parity check with acc=0, stay IDLE. An empty event must carry parity 0.
  - ACCUM: accepted EE word -> check in_data[PAR_BIT] against acc; mismatch -> par_err. Go to IDLE.
  - Length check (IDLE or ACCUM): an accepted non-EE word when word_cnt==MAX_WORDS -> len_err, go to DRAIN. Otherwise word_cnt increments.
  - DRAIN: words are still forwarded, with no accumulation or check. Accepted EE word -> IDLE with no par_err. Only one len_err is raised per event.
- Counters:
  - evt_count increments on every accepted EE word, in all states.
  - err_count increments on each par_err or len_err, saturates at 2^CNT_W-1.
  - clear_counts wins over a simultaneous increment, and is honoured even while out_hold=1.
- Reset values: state IDLE, acc 0, word_cnt 0; out_data 0, out_ee 0, out_valid 0, par_err 0, len_err 0, err_count 0, evt_count 0.
- Reset mid-event discards the partial event: the next word starts a new event in IDLE.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on out_* after edge N, with its flags in the same cycle.
- Full throughput, one word per cycle, with no bubbles between events.
- A back-to-back EE followed by a data word on the next cycle starts the new event with acc=0.
- in_hold has zero latency from out_hold. Upstream must hold in_data/in_ee/in_valid stable while in_hold=1.
- Counters update on the same edge that registers the corresponding output word.

## Test plan
- Words 0x000001, 0x000003, then EE 0x200000 (bit21=1) -> no par_err, evt_count=1, outputs delayed 1 cycle.
- Same data words, EE 0x000000 -> par_err pulse aligned with out_ee, err_count=1.
- EE only (0x000000), then EE only (0x200000) -> first event passes; second raises par_err, err_count=1, evt_count=2.
- MAX_WORDS=4: 6 data words, then an EE with wrong parity -> len_err on the 5th word and no par_err; EE returns to IDLE, err_count=1.
- out_hold=1 for 3 cycles mid-event with in_valid=1 -> outputs frozen, in_hold=1, acc unchanged; the final parity result is identical to the no-hold run.
- err_count preloaded to 0xFFFF by repeated errors, then another error -> stays 0xFFFF. clear_counts asserted on the same cycle as an EE -> both counters read 0. Reset mid-event -> all outputs 0 and the next event checks cleanly.
